// File: rtl/rt_block_feeder_if.sv
// Quadlet receive stream feeding the real-time block writer.
// The master is the Ethernet/Firewire receive path and the slave is the feeder.
interface rt_block_feeder_if;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic [31:0] in_data;
    logic        in_abort;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_first,
        output in_last,
        output in_data,
        output in_abort,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_first,
        input  in_last,
        input  in_data,
        input  in_abort,
        output in_ready
    );
endinterface

// File: rtl/rt_block_feeder.sv
// Buffers one real-time block-write packet (NumDac DAC quadlets plus one control quadlet).
// The packet is replayed to the writer only if it completes cleanly; the control quadlet is always written last.
module rt_block_feeder #(
    parameter int unsigned NumDac  = 4,
    parameter int unsigned Holdoff = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    rt_block_feeder_if.slave         in_if,
    input  logic                     clear_cnt_i,
    output logic                     rt_write_en_o,
    output logic [2:0]               rt_write_addr_o,
    output logic [31:0]              rt_write_data_o,
    output logic [15:0]              good_cnt_o,
    output logic [7:0]               err_len_cnt_o,
    output logic [7:0]               err_abort_cnt_o,
    output logic [7:0]               err_busy_cnt_o
);
    localparam int unsigned HoldW  = $clog2(Holdoff + 1);
    localparam logic [2:0]  LastQc = 3'(NumDac);
    localparam logic [2:0]  QcSat  = 3'(NumDac + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCommit, StHoldoff} state_e;

    state_e           state_q;
    logic [31:0]      dbuf_q [NumDac+1];
    logic [2:0]       qc_q;
    logic [2:0]       idx_q;
    logic [HoldW-1:0] hold_q;
    logic             ready_q;
    logic             wr_en_q;
    logic [2:0]       wr_addr_q;
    logic [31:0]      wr_data_q;
    logic [15:0]      good_q;
    logic [7:0]       err_len_q;
    logic [7:0]       err_abort_q;
    logic [7:0]       err_busy_q;

    logic             start;
    logic [31:0]      rd_data;
    logic [1:0]       len_ev;
    logic             abort_ev;
    logic             busy_ev;
    logic             good_ev;

    assign start = in_if.in_valid & in_if.in_first;

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i <= NumDac; i++) begin
            if (idx_q == 3'(i)) rd_data = dbuf_q[i];
        end
    end

    // Counter events; a restart that is itself a one-beat packet is two length errors.
    always_comb begin
        len_ev   = 2'd0;
        abort_ev = 1'b0;
        busy_ev  = 1'b0;
        good_ev  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) len_ev = {1'b0, in_if.in_last};
            end
            StRecv: begin
                if (in_if.in_abort) begin
                    abort_ev = 1'b1;
                end else if (start) begin
                    len_ev = in_if.in_last ? 2'd2 : 2'd1;
                end else if (in_if.in_valid && in_if.in_last && qc_q != LastQc) begin
                    len_ev = 2'd1;
                end
            end
            StCommit: begin
                busy_ev = start;
                good_ev = (idx_q == LastQc);
            end
            StHoldoff: begin
                busy_ev = start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            qc_q      <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            ready_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int unsigned i = 0; i <= NumDac; i++) dbuf_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        dbuf_q[0] <= in_if.in_data;
                        qc_q      <= 3'd1;
                        if (!in_if.in_last) state_q <= StRecv;
                    end
                end
                StRecv: begin
                    if (in_if.in_abort) begin
                        state_q <= StIdle;
                    end else if (start) begin
                        dbuf_q[0] <= in_if.in_data;
                        qc_q      <= 3'd1;
                        state_q   <= in_if.in_last ? StIdle : StRecv;
                    end else if (in_if.in_valid) begin
                        for (int unsigned i = 1; i <= NumDac; i++) begin
                            if (qc_q == 3'(i)) dbuf_q[i] <= in_if.in_data;
                        end
                        if (qc_q != QcSat) qc_q <= qc_q + 3'd1;
                        if (in_if.in_last) begin
                            if (qc_q == LastQc) begin
                                state_q <= StCommit;
                                ready_q <= 1'b0;
                                idx_q   <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                StCommit: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= (idx_q == LastQc) ? 3'd4 : idx_q;
                    wr_data_q <= rd_data;
                    if (idx_q == LastQc) begin
                        state_q <= StHoldoff;
                        hold_q  <= '0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                StHoldoff: begin
                    wr_en_q   <= 1'b0;
                    wr_addr_q <= '0;
                    wr_data_q <= '0;
                    if (hold_q == HoldW'(Holdoff - 1)) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // A clear wins over any increment on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            good_q      <= '0;
            err_len_q   <= '0;
            err_abort_q <= '0;
            err_busy_q  <= '0;
        end else if (clear_cnt_i) begin
            good_q      <= '0;
            err_len_q   <= '0;
            err_abort_q <= '0;
            err_busy_q  <= '0;
        end else begin
            good_q      <= good_q + 16'(good_ev);
            err_len_q   <= sat_add(err_len_q, len_ev);
            err_abort_q <= sat_add(err_abort_q, {1'b0, abort_ev});
            err_busy_q  <= sat_add(err_busy_q, {1'b0, busy_ev});
        end
    end

    assign in_if.in_ready   = ready_q;
    assign rt_write_en_o    = wr_en_q;
    assign rt_write_addr_o  = wr_addr_q;
    assign rt_write_data_o  = wr_data_q;
    assign good_cnt_o       = good_q;
    assign err_len_cnt_o    = err_len_q;
    assign err_abort_cnt_o  = err_abort_q;
    assign err_busy_cnt_o   = err_busy_q;
endmodule
